// File: rtl/dmem_responder.sv
// Data-memory responder: accepts word-aligned read/write requests with a byte-lane
// mask and returns one response pulse a fixed LATENCY cycles after acceptance.
//
//   state | meaning
//   IDLE  | ready; a request with ren|wen is accepted on the next edge
//   BUSY  | waiting out the latency; the down-counter is nonzero here
//   RESP  | one-cycle valid pulse carrying the registered rdata/err
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_ready,
  output logic        o_dmem_valid,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned CW       = 3;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam bit          DIRECT   = (LATENCY == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] index;
  logic          err_misalign, err_range, err_both, req_err;
  logic          accept, do_write;
  logic [31:0]   cur_word, merged_word;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  // Address decode: the subtraction wraps, so addresses below BASE_ADDR land
  // far above the array and are caught by the range check.
  assign offset       = i_dmem_addr - BASE_ADDR;
  assign index        = offset[AW+1:2];
  assign err_misalign = |offset[1:0];
  assign err_range    = |offset[31:AW+2];
  assign err_both     = i_dmem_ren & i_dmem_wen;
  assign req_err      = err_misalign | err_range | err_both;

  assign accept   = (state == ST_IDLE) && (i_dmem_ren || i_dmem_wen);
  assign do_write = accept && i_dmem_wen && !req_err;
  assign cur_word = mem[index];

  // Ready is forced low while reset is held, even though the state already reads IDLE.
  assign o_dmem_ready = (state == ST_IDLE) && i_rst_n;
  assign o_dmem_valid = (state == ST_RESP);
  assign o_dmem_rdata = resp_rdata;
  assign o_dmem_err   = resp_err;

  // Byte-lane merge of write data into the currently stored word.
  always_comb begin
    merged_word = cur_word;
    for (int k = 0; k < 4; k++) begin
      if (i_dmem_mask[k]) merged_word[8*k +: 8] = i_dmem_wdata[8*k +: 8];
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: BUSY lasts LATENCY-1 cycles, so RESP lands LATENCY cycles after acceptance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = DIRECT ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Array write in the acceptance cycle; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[index] <= merged_word;
  end

  // Response registers captured at acceptance and held until the next acceptance.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_err <= req_err;
      if (req_err)         resp_rdata <= '0;
      else if (i_dmem_wen) resp_rdata <= merged_word;
      else                 resp_rdata <= cur_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1 and 8, with different
// base/depth) share one stimulus bus; only the targeted instance sees ren/wen.
module tb_dmem_responder;

  localparam int          L0 = 2, L1 = 1, L2 = 8;
  localparam int          D0 = 1024, D1 = 1024, D2 = 16;
  localparam logic [31:0] B0 = 32'h0000_0000, B1 = 32'h8000_0000, B2 = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic [3:0]  mask;
  logic [2:0]  ren, wen;
  logic [2:0]  ready_v, valid_v, err_v;
  logic [31:0] rdata_v [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mm [int];

  typedef struct {
    int          inst;
    logic [31:0] a;
    logic        r;
    logic        w;
    logic [31:0] d;
    logic [3:0]  m;
    bit          bp;
    logic        e;
    logic [31:0] x;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(D0), .BASE_ADDR(B0), .LATENCY(L0)) u_l2 (
    .clk(clk), .i_rst_n(rst_n), .i_dmem_addr(addr), .i_dmem_ren(ren[0]), .i_dmem_wen(wen[0]),
    .i_dmem_wdata(wdata), .i_dmem_mask(mask), .o_dmem_ready(ready_v[0]), .o_dmem_valid(valid_v[0]),
    .o_dmem_rdata(rdata_v[0]), .o_dmem_err(err_v[0]));

  dmem_responder #(.DEPTH_WORDS(D1), .BASE_ADDR(B1), .LATENCY(L1)) u_l1 (
    .clk(clk), .i_rst_n(rst_n), .i_dmem_addr(addr), .i_dmem_ren(ren[1]), .i_dmem_wen(wen[1]),
    .i_dmem_wdata(wdata), .i_dmem_mask(mask), .o_dmem_ready(ready_v[1]), .o_dmem_valid(valid_v[1]),
    .o_dmem_rdata(rdata_v[1]), .o_dmem_err(err_v[1]));

  dmem_responder #(.DEPTH_WORDS(D2), .BASE_ADDR(B2), .LATENCY(L2)) u_l8 (
    .clk(clk), .i_rst_n(rst_n), .i_dmem_addr(addr), .i_dmem_ren(ren[2]), .i_dmem_wen(wen[2]),
    .i_dmem_wdata(wdata), .i_dmem_mask(mask), .o_dmem_ready(ready_v[2]), .o_dmem_valid(valid_v[2]),
    .o_dmem_rdata(rdata_v[2]), .o_dmem_err(err_v[2]));

  function automatic int lat_of(input int i);
    case (i)
      0: return L0;
      1: return L1;
      default: return L2;
    endcase
  endfunction

  function automatic int depth_of(input int i);
    case (i)
      0: return D0;
      1: return D1;
      default: return D2;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int i);
    case (i)
      0: return B0;
      1: return B1;
      default: return B2;
    endcase
  endfunction

  // Scratch region (word index start / count) used by random traffic.
  function automatic int rs_of(input int i);
    return (i == 2) ? 8 : 64;
  endfunction

  function automatic int rn_of(input int i);
    return (i == 2) ? 4 : 16;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ren = '0;
    wen = '0;
    addr = '0;
    wdata = '0;
    mask = '0;
  endtask

  task automatic drive(input int inst, input logic [31:0] a, input logic r, input logic w,
                       input logic [31:0] d, input logic [3:0] m);
    idle();
    addr = a;
    wdata = d;
    mask = m;
    ren[inst] = r;
    wen[inst] = w;
  endtask

  // A competing legal write, presented while the responder is not ready.
  task automatic drive_bp(input int inst);
    drive(inst, base_of(inst) + 32'(4 * (rs_of(inst) + $urandom_range(0, rn_of(inst) - 1))),
          1'b0, 1'b1, $urandom, 4'hF);
  endtask

  // Reference model: plain word store keyed by (instance, word index).
  task automatic model(input int inst, input logic [31:0] a, input logic r, input logic w,
                       input logic [31:0] d, input logic [3:0] m,
                       output logic e, output logic [31:0] x);
    logic [31:0] off;
    logic [31:0] word;
    int          key;
    off = a - base_of(inst);
    e = (a % 4 != 0) || (longint'(off / 4) >= longint'(depth_of(inst))) || (r && w);
    x = '0;
    if (!e) begin
      key  = inst * 65536 + int'(off / 4);
      word = mm.exists(key) ? mm[key] : 32'h0;
      if (w) begin
        for (int k = 0; k < 4; k++) if (m[k]) word[8*k +: 8] = d[8*k +: 8];
        mm[key] = word;
      end
      x = word;
    end
  endtask

  task automatic run_req(input int inst, input logic [31:0] a, input logic r, input logic w,
                         input logic [31:0] d, input logic [3:0] m, input bit bp,
                         input logic e, input logic [31:0] x, input string nm);
    int n;
    int early;
    chk({nm, " ready_before"}, 32'(ready_v[inst]), 32'd1);
    drive(inst, a, r, w, d, m);
    @(negedge clk);
    n = 1;
    early = 0;
    while (!valid_v[inst] && n < 20) begin
      if (ready_v[inst]) early++;
      if (bp) drive_bp(inst); else idle();
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(lat_of(inst)));
    chk({nm, " ready_while_busy"}, 32'(early + int'(ready_v[inst])), 32'd0);
    chk({nm, " err"}, 32'(err_v[inst]), 32'(e));
    chk({nm, " rdata"}, rdata_v[inst], x);
    if (bp) drive_bp(inst); else idle();
    @(negedge clk);
    idle();
    chk({nm, " valid_single"}, 32'(valid_v[inst]), 32'd0);
    chk({nm, " ready_after"}, 32'(ready_v[inst]), 32'd1);
  endtask

  task automatic add(input int inst, input logic [31:0] a, input logic r, input logic w,
                     input logic [31:0] d, input logic [3:0] m, input bit bp,
                     input logic e, input logic [31:0] x, input string nm);
    vec_t v;
    v.inst = inst; v.a = a; v.r = r; v.w = w; v.d = d; v.m = m;
    v.bp = bp; v.e = e; v.x = x; v.nm = nm;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e, r, w;
    logic [31:0] a, d, x;
    logic [3:0]  m;
    int          sel;

    // inst 0: LATENCY=2, base 0, 1024 words
    add(0, 32'h0000_0000, 0, 1, 32'h1234_5678, 4'hF, 0, 0, 32'h1234_5678, "wr0_w0");
    add(0, 32'h0000_0010, 0, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'hDEAD_BEEF, "wr0_10");
    add(0, 32'h0000_0010, 1, 0, 32'h0,         4'hF, 0, 0, 32'hDEAD_BEEF, "rd0_10");
    add(0, 32'h0000_0010, 0, 1, 32'h1122_3344, 4'h4, 0, 0, 32'hDE22_BEEF, "merge0");
    add(0, 32'h0000_0010, 1, 0, 32'h0,         4'h0, 0, 0, 32'hDE22_BEEF, "rd0_merge");
    add(0, 32'h0000_0020, 0, 1, 32'h0,         4'hF, 0, 0, 32'h0,         "clr0_20");
    add(0, 32'h0000_0020, 0, 1, 32'hAAAA_5555, 4'hC, 0, 0, 32'hAAAA_0000, "half0");
    add(0, 32'h0000_0020, 1, 0, 32'h0,         4'hF, 0, 0, 32'hAAAA_0000, "rd0_half");
    add(0, 32'h0000_0012, 1, 0, 32'h0,         4'hF, 0, 1, 32'h0,         "misal_rd");
    add(0, 32'h0000_0012, 0, 1, 32'hFFFF_FFFF, 4'hF, 0, 1, 32'h0,         "misal_wr");
    add(0, 32'h0000_1000, 0, 1, 32'hFFFF_FFFF, 4'hF, 0, 1, 32'h0,         "oob_wr");
    add(0, 32'h0000_1000, 1, 0, 32'h0,         4'hF, 0, 1, 32'h0,         "oob_rd");
    add(0, 32'h0000_0010, 1, 1, 32'hFFFF_FFFF, 4'hF, 0, 1, 32'h0,         "rw_both");
    add(0, 32'h0000_0010, 1, 0, 32'h0,         4'hF, 0, 0, 32'hDE22_BEEF, "rd0_after_err");
    add(0, 32'h0000_0000, 1, 0, 32'h0,         4'hF, 0, 0, 32'h1234_5678, "rd0_alias");
    add(0, 32'h0000_0020, 0, 1, 32'hFFFF_FFFF, 4'h0, 0, 0, 32'hAAAA_0000, "mask0_wr");
    add(0, 32'h0000_0020, 1, 0, 32'h0,         4'hF, 0, 0, 32'hAAAA_0000, "rd0_mask0");
    // inst 1: LATENCY=1, base 0x8000_0000, back-pressure on every busy cycle
    add(1, 32'h8000_0004, 0, 1, 32'hCAFE_F00D, 4'hF, 1, 0, 32'hCAFE_F00D, "wr1_4");
    add(1, 32'h8000_0004, 1, 0, 32'h0,         4'hF, 1, 0, 32'hCAFE_F00D, "rd1_4");
    add(1, 32'h8000_0FFC, 0, 1, 32'h0BAD_C0DE, 4'hF, 1, 0, 32'h0BAD_C0DE, "wr1_last");
    add(1, 32'h8000_0FFC, 1, 0, 32'h0,         4'hF, 1, 0, 32'h0BAD_C0DE, "rd1_last");
    add(1, 32'h7FFF_FFFC, 0, 1, 32'h0,         4'hF, 1, 1, 32'h0,         "below_base");
    add(1, 32'h8000_1000, 1, 0, 32'h0,         4'hF, 1, 1, 32'h0,         "oob1");
    add(1, 32'h8000_0004, 0, 1, 32'h00FF_00FF, 4'h5, 1, 0, 32'hCAFF_F0FF, "merge1");
    add(1, 32'h8000_0004, 1, 0, 32'h0,         4'hF, 1, 0, 32'hCAFF_F0FF, "rd1_merge");
    // inst 2: LATENCY=8, 16 words
    add(2, 32'h0000_003C, 0, 1, 32'h1357_9BDF, 4'hF, 1, 0, 32'h1357_9BDF, "wr2_last");
    add(2, 32'h0000_003C, 1, 0, 32'h0,         4'hF, 1, 0, 32'h1357_9BDF, "rd2_last");
    add(2, 32'h0000_0000, 0, 1, 32'h2468_ACE0, 4'hF, 1, 0, 32'h2468_ACE0, "wr2_0");
    add(2, 32'h0000_0040, 0, 1, 32'hFFFF_FFFF, 4'hF, 1, 1, 32'h0,         "oob2");
    add(2, 32'h0000_0000, 1, 0, 32'h0,         4'hF, 1, 0, 32'h2468_ACE0, "rd2_alias");
    add(2, 32'h0000_003E, 1, 0, 32'h0,         4'hF, 1, 1, 32'h0,         "misal2");

    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst ready", 32'(ready_v[i]), 32'd0);
      chk("rst valid", 32'(valid_v[i]), 32'd0);
      chk("rst err", 32'(err_v[i]), 32'd0);
      chk("rst rdata", rdata_v[i], 32'h0);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("release ready", 32'(ready_v[i]), 32'd1);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      run_req(tbl[i].inst, tbl[i].a, tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].m,
              tbl[i].bp, tbl[i].e, tbl[i].x, tbl[i].nm);
    end

    // Reset while a read is in flight on the LATENCY=2 instance.
    drive(0, 32'h0000_0010, 1'b1, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    idle();
    chk("midrst busy_ready", 32'(ready_v[0]), 32'd0);
    chk("midrst busy_valid", 32'(valid_v[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst ready", 32'(ready_v[0]), 32'd0);
    chk("midrst valid", 32'(valid_v[0]), 32'd0);
    chk("midrst err", 32'(err_v[0]), 32'd0);
    chk("midrst rdata", rdata_v[0], 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst no_valid", 32'(valid_v[0]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("midrst release_ready", 32'(ready_v[0]), 32'd1);
    @(negedge clk);
    chk("midrst idle_valid", 32'(valid_v[0]), 32'd0);
    run_req(0, 32'h0000_0010, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 32'hDE22_BEEF, "rd_after_rst");

    // Randomized traffic against the reference model.
    for (int inst = 0; inst < 3; inst++) begin
      for (int j = 0; j < rn_of(inst); j++) begin
        a = base_of(inst) + 32'(4 * (rs_of(inst) + j));
        d = $urandom;
        model(inst, a, 1'b0, 1'b1, d, 4'hF, e, x);
        run_req(inst, a, 1'b0, 1'b1, d, 4'hF, 1'b0, e, x, "rand_init");
      end
      for (int j = 0; j < 40; j++) begin
        sel = $urandom_range(0, 9);
        a = base_of(inst) + 32'(4 * (rs_of(inst) + $urandom_range(0, rn_of(inst) - 1)));
        d = $urandom;
        m = 4'($urandom_range(0, 15));
        r = 1'b0;
        w = 1'b0;
        if (sel < 4) r = 1'b1;
        else if (sel < 7) w = 1'b1;
        else if (sel == 7) begin
          a = a + 32'($urandom_range(1, 3));
          if ($urandom_range(0, 1) == 1) r = 1'b1; else w = 1'b1;
        end else if (sel == 8) begin
          if ($urandom_range(0, 1) == 1)
            a = base_of(inst) + 32'(depth_of(inst) * 4) + 32'(4 * $urandom_range(0, 255));
          else
            a = base_of(inst) - 32'(4 * $urandom_range(1, 8));
          if ($urandom_range(0, 1) == 1) r = 1'b1; else w = 1'b1;
        end else begin
          r = 1'b1;
          w = 1'b1;
        end
        model(inst, a, r, w, d, m, e, x);
        run_req(inst, a, r, w, d, m, bit'($urandom_range(0, 1)), e, x, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
